// File: rtl/ula_muldiv_ctrl.sv
// ALU control decoder plus a multi-cycle mult/multu/div/divu sequencer with HI/LO result registers.
// One shift-add or restoring shift-subtract step per cycle on operand magnitudes; signs are applied in a final fix-up cycle.
module ula_muldiv_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       ALUOp,
    input  logic [5:0]       funct,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [3:0]       ALUCtrl,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t                 state_reg, state_next;
    logic [CNT_W-1:0]       cnt_reg;
    logic [2*WIDTH-1:0]     acc_reg;
    logic [WIDTH-1:0]       opnd_reg;
    logic                   div_reg;
    logic                   neg_lo_reg;
    logic                   neg_hi_reg;
    logic [WIDTH-1:0]       hi_reg;
    logic [WIDTH-1:0]       lo_reg;

    // ---------------- ALU control decode ----------------
    always_comb begin
        ALUCtrl = 4'b0010;
        case (ALUOp)
            3'b000: ALUCtrl = 4'b0010;
            3'b001: ALUCtrl = 4'b0110;
            3'b011: ALUCtrl = 4'b0111;
            3'b100: ALUCtrl = 4'b1001;
            3'b101: ALUCtrl = 4'b1010;
            3'b110: ALUCtrl = 4'b1011;
            3'b111: ALUCtrl = 4'b0111;
            3'b010: begin
                case (funct)
                    6'b100000, 6'b100001: ALUCtrl = 4'b0010;
                    6'b100010, 6'b100011: ALUCtrl = 4'b0110;
                    6'b100100:            ALUCtrl = 4'b0000;
                    6'b100101:            ALUCtrl = 4'b0001;
                    6'b100110:            ALUCtrl = 4'b0011;
                    6'b100111:            ALUCtrl = 4'b0100;
                    6'b101010:            ALUCtrl = 4'b0111;
                    6'b101011:            ALUCtrl = 4'b1000;
                    6'b000000, 6'b000100: ALUCtrl = 4'b1001;
                    6'b000010, 6'b000110: ALUCtrl = 4'b1010;
                    6'b000011, 6'b000111: ALUCtrl = 4'b1011;
                    6'b011000:            ALUCtrl = 4'b1100;
                    6'b011001:            ALUCtrl = 4'b1101;
                    6'b011010:            ALUCtrl = 4'b1110;
                    6'b011011:            ALUCtrl = 4'b1111;
                    default:              ALUCtrl = 4'b0010;
                endcase
            end
            default: ALUCtrl = 4'b0010;
        endcase
    end

    // ---------------- launch decode ----------------
    logic             accept;
    logic             is_div_in;
    logic             is_signed_in;
    logic             a_neg;
    logic             b_neg;
    logic             div_zero_in;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    // Codes 1100..1111: bit1 selects divide, bit0 selects the unsigned variant.
    assign accept       = (state_reg == IDLE) && start && (ALUCtrl[3:2] == 2'b11);
    assign is_div_in    = ALUCtrl[1];
    assign is_signed_in = ~ALUCtrl[0];
    assign a_neg        = is_signed_in & a[WIDTH-1];
    assign b_neg        = is_signed_in & b[WIDTH-1];
    assign mag_a        = a_neg ? (~a + WIDTH'(1)) : a;
    assign mag_b        = b_neg ? (~b + WIDTH'(1)) : b;
    assign div_zero_in  = is_div_in && (b == '0);

    // ---------------- datapath step ----------------
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_shift;
    logic                 div_fits;
    logic [WIDTH-1:0]     div_sub;
    logic [2*WIDTH-1:0]   div_next;

    // Multiplier sits in the low half and retires one bit per step as the product shifts in.
    assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
    assign mul_next = {mul_sum, acc_reg[WIDTH-1:1]};

    // Remainder in the high half, dividend bits shifted out of the low half as quotient bits shift in.
    assign div_shift = acc_reg[2*WIDTH-1:WIDTH-1];
    assign div_fits  = div_shift >= {1'b0, opnd_reg};
    assign div_sub   = div_shift[WIDTH-1:0] - opnd_reg;
    assign div_next  = div_fits ? {div_sub, acc_reg[WIDTH-2:0], 1'b1}
                                : {div_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};

    // ---------------- sign fix-up ----------------
    logic [2*WIDTH-1:0] fix_prod;
    logic [WIDTH-1:0]   fix_lo;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   hi_next;
    logic [WIDTH-1:0]   lo_next;

    assign fix_prod = neg_lo_reg ? (~acc_reg + (2*WIDTH)'(1)) : acc_reg;
    assign fix_lo   = neg_lo_reg ? (~acc_reg[WIDTH-1:0] + WIDTH'(1)) : acc_reg[WIDTH-1:0];
    assign fix_hi   = neg_hi_reg ? (~acc_reg[2*WIDTH-1:WIDTH] + WIDTH'(1)) : acc_reg[2*WIDTH-1:WIDTH];
    assign hi_next  = div_reg ? fix_hi : fix_prod[2*WIDTH-1:WIDTH];
    assign lo_next  = div_reg ? fix_lo : fix_prod[WIDTH-1:0];

    // ---------------- FSM ----------------
    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = div_zero_in ? FIX : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt_reg == CNT_W'(WIDTH - 1)) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            acc_reg    <= '0;
            opnd_reg   <= '0;
            div_reg    <= 1'b0;
            neg_lo_reg <= 1'b0;
            neg_hi_reg <= 1'b0;
            hi_reg     <= '0;
            lo_reg     <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                cnt_reg  <= '0;
                div_reg  <= is_div_in;
                opnd_reg <= mag_b;
                if (div_zero_in) begin
                    // Divide-by-zero result is preloaded and passes through fix-up unchanged.
                    acc_reg    <= {a, {WIDTH{1'b1}}};
                    neg_lo_reg <= 1'b0;
                    neg_hi_reg <= 1'b0;
                end else begin
                    acc_reg    <= {{WIDTH{1'b0}}, mag_a};
                    neg_lo_reg <= a_neg ^ b_neg;
                    neg_hi_reg <= is_div_in ? a_neg : (a_neg ^ b_neg);
                end
            end
            if (state_reg == RUN) begin
                acc_reg <= div_reg ? div_next : mul_next;
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
            if (state_reg == FIX) begin
                hi_reg <= hi_next;
                lo_reg <= lo_next;
            end
        end
    end

    assign hi = hi_reg;
    assign lo = lo_reg;

endmodule

// File: tb/tb_ula_muldiv_ctrl.sv
// Self-checking bench for ula_muldiv_ctrl at WIDTH=32: decode sweep, mult/div scoreboard, abort and reset cases.
module tb_ula_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  ALUOp;
    logic [5:0]  funct;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ALUCtrl;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    exp_t sb_q[$];

    ula_muldiv_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .ALUOp(ALUOp), .funct(funct), .start(start),
        .a(a), .b(b), .ALUCtrl(ALUCtrl), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] ref_ctrl(input logic [2:0] op, input logic [5:0] f);
        logic [3:0] r;
        case (op)
            3'd0: r = 4'b0010;
            3'd1: r = 4'b0110;
            3'd3: r = 4'b0111;
            3'd4: r = 4'b1001;
            3'd5: r = 4'b1010;
            3'd6: r = 4'b1011;
            3'd7: r = 4'b0111;
            default: begin
                case (f)
                    6'h20, 6'h21: r = 4'b0010;
                    6'h22, 6'h23: r = 4'b0110;
                    6'h24: r = 4'b0000;
                    6'h25: r = 4'b0001;
                    6'h26: r = 4'b0011;
                    6'h27: r = 4'b0100;
                    6'h2A: r = 4'b0111;
                    6'h2B: r = 4'b1000;
                    6'h00, 6'h04: r = 4'b1001;
                    6'h02, 6'h06: r = 4'b1010;
                    6'h03, 6'h07: r = 4'b1011;
                    6'h18: r = 4'b1100;
                    6'h19: r = 4'b1101;
                    6'h1A: r = 4'b1110;
                    6'h1B: r = 4'b1111;
                    default: r = 4'b0010;
                endcase
            end
        endcase
        return r;
    endfunction

    function automatic exp_t model(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
        exp_t        e;
        logic [63:0] p;
        e.lat = 34;
        e.hi  = '0;
        e.lo  = '0;
        case (f)
            6'h18: begin
                p = longint'($signed(x)) * longint'($signed(y));
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            6'h19: begin
                p = {32'b0, x} * {32'b0, y};
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            6'h1A: begin
                if (y == 32'd0) begin
                    e.hi = x; e.lo = 32'hFFFF_FFFF; e.lat = 2;
                end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    e.hi = 32'd0; e.lo = 32'h8000_0000;
                end else begin
                    e.lo = $signed(x) / $signed(y);
                    e.hi = $signed(x) % $signed(y);
                end
            end
            default: begin
                if (y == 32'd0) begin
                    e.hi = x; e.lo = 32'hFFFF_FFFF; e.lat = 2;
                end else begin
                    e.lo = x / y;
                    e.hi = x % y;
                end
            end
        endcase
        return e;
    endfunction

    // Launch one op, scramble inputs after acceptance, optionally re-pulse start mid-run.
    task automatic run_op(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y, input bit repulse);
        exp_t e;
        int   n;
        sb_q.push_back(model(f, x, y));
        @(negedge clk);
        ALUOp = 3'b010; funct = f; a = x; b = y; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom; funct = 6'h20;
        n = 1;
        check("busy_run", busy, 1);
        while (!done && n < 100) begin
            if (repulse && n == 10) begin
                start = 1'b1; funct = 6'h19; a = 32'h1234; b = 32'h5678;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        e = sb_q.pop_front();
        check("latency", n, e.lat);
        check("hi", hi, e.hi);
        check("lo", lo, e.lo);
        @(negedge clk);
        check("done_pulse", done, 0);
        check("busy_after", busy, 0);
        check("hi_hold", hi, e.hi);
        $display("op funct=%h a=%h b=%h -> hi=%h lo=%h latency=%0d", f, x, y, hi, lo, n);
    endtask

    initial begin
        int   n;
        bit   seen;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [5:0]  rf;

        rst = 1'b1; start = 1'b0; ALUOp = 3'b000; funct = 6'h00; a = '0; b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);

        for (int op = 0; op < 8; op++) begin
            if (op != 2) begin
                ALUOp = op[2:0]; funct = 6'($urandom);
                #1;
                check("aluop_decode", ALUCtrl, ref_ctrl(op[2:0], funct));
            end
        end
        for (int fc = 0; fc < 64; fc++) begin
            ALUOp = 3'b010; funct = fc[5:0];
            #1;
            check("funct_decode", ALUCtrl, ref_ctrl(3'b010, fc[5:0]));
        end
        $display("decode sweep complete");

        @(negedge clk);
        ALUOp = 3'b000; funct = 6'h18; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("non_muldiv_start", busy, 0);
        $display("start with non-muldiv decode: busy=%b", busy);

        run_op(6'h18, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
        run_op(6'h19, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1);
        run_op(6'h1A, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
        run_op(6'h1B, 32'h0000_0007, 32'h0000_0002, 1'b0);
        run_op(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(6'h1B, 32'h0000_0005, 32'h0000_0000, 1'b0);
        run_op(6'h1A, 32'hFFFF_FFF0, 32'h0000_0000, 1'b0);
        for (int i = 0; i < 8; i++) begin
            rf = 6'h18 + 6'(i % 4);
            ra = $urandom;
            rb = (i == 5) ? 32'h0000_0003 : $urandom;
            run_op(rf, ra, rb, 1'b0);
        end

        // Abort a mult mid-run with reset; second start must be ignored.
        @(negedge clk);
        ALUOp = 3'b010; funct = 6'h18; a = 32'd3; b = 32'd5; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (n < 20) begin
            if (n == 10) begin
                start = 1'b1; funct = 6'h19; a = 32'd9; b = 32'd9;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        check("busy_before_rst", busy, 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_hi", hi, 0);
        check("abort_lo", lo, 0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("abort_no_done", seen, 0);
        $display("mid-run reset: busy=%b hi=%h lo=%h done_seen=%b", busy, hi, lo, seen);

        // Reset and start together: reset wins.
        @(negedge clk);
        ALUOp = 3'b010; funct = 6'h1B; a = 32'd40; b = 32'd6; start = 1'b1; rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("rst_start_busy", busy, 0);
        @(negedge clk);
        check("rst_start_busy2", busy, 0);
        check("rst_start_done", done, 0);
        $display("reset with start: busy=%b done=%b", busy, done);

        run_op(6'h1A, 32'hFFFF_FF9C, 32'h0000_0007, 1'b0);
        run_op(6'h18, 32'h8000_0000, 32'h8000_0000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ula_muldiv_ctrl.md
ULA_MULDIV_CTRL -- requirements
Module: ula_muldiv_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/HI/LO width in bits (legal: 8..64, even).
REQ-002 SHALL have parameter CNT_W, default 6, meaning iteration counter width, with 2^CNT_W > WIDTH.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port ALUOp  input  3  main-control ALU operation class.
REQ-006 SHALL have port funct  input  6  R-type function field.
REQ-007 SHALL have port start  input  1  request to launch a mult/div when the decode selects one.
REQ-008 SHALL have ports a, b  input  WIDTH  rs and rt operands, sampled only on an accepted start.
REQ-009 SHALL have port ALUCtrl  output  4  combinational ALU control code.
REQ-010 SHALL have ports busy, done  output  1  sequencer running; one-cycle completion pulse.
REQ-011 SHALL have ports hi, lo  output  WIDTH  result registers.

Function
REQ-012 ALUCtrl SHALL decode combinationally: ALUOp 000->0010, 001->0110, 011->0111, 100->1001, 101->1010, 110->1011, 111->0111.
REQ-013 With ALUOp=010, ALUCtrl SHALL map funct: 100000/100001->0010, 100010/100011->0110, 100100->0000, 100101->0001, 100110->0011, 100111->0100, 101010->0111, 101011->1000, 000000/000100->1001, 000010/000110->1010, 000011/000111->1011, 011000->1100, 011001->1101, 011010->1110, 011011->1111; any other funct->0010 (no latch).
REQ-014 Start SHALL be accepted only in IDLE, with start=1 and ALUCtrl in {1100 mult, 1101 multu, 1110 div, 1111 divu}; otherwise ignored (including start while busy).
REQ-015 FSM states: IDLE, RUN, FIX, DONE; IDLE->RUN on accept; RUN->FIX after exactly WIDTH iterations; FIX->DONE; DONE->IDLE, unconditionally, one cycle each.
REQ-016 Accept with div/divu and b==0 SHALL go IDLE->FIX directly; result lo=all ones, hi=a.
REQ-017 On accept, op type, signedness, operand magnitudes (signed ops: absolute value, two's complement) and result signs SHALL be latched; counter loads 0.
REQ-018 RUN, mult: one shift-add step per cycle (2*WIDTH-bit unsigned product of magnitudes).
REQ-019 RUN, div: one restoring shift-subtract step per cycle (unsigned quotient/remainder of magnitudes).
REQ-020 FIX SHALL apply signs: mult product negated if operand signs differ; quotient negated if signs differ, remainder takes dividend sign (truncation toward zero); unsigned ops unchanged.
REQ-021 hi/lo SHALL be written only on the FIX->DONE edge: mult hi=product[2W-1:W], lo=product[W-1:0]; div lo=quotient, hi=remainder; otherwise hold.
REQ-022 Latency: accept edge at cycle 0 -> done=1 in cycle WIDTH+2 (cycle 2 for divide-by-zero), for exactly one cycle.
REQ-023 busy SHALL be 1 in RUN and FIX, 0 in IDLE and DONE; a new start is acceptable the cycle after done.
REQ-024 Signed div of most-negative by -1 SHALL yield lo=most-negative, hi=0 (modulo-2^WIDTH wrap, no flag).
REQ-025 Changes on a, b, ALUOp, funct after accept SHALL NOT affect the running operation (ALUCtrl output still tracks inputs).

Reset
REQ-026 rst=1 at a rising edge SHALL force IDLE, counter=0, busy=0, done=0, hi=0, lo=0, in any state, including mid-RUN (operation discarded, no done pulse).
REQ-027 rst and start in the same cycle: rst wins; start ignored.

Verification (WIDTH=32)
REQ-028 Decode sweep: all ALUOp values, and all 64 funct codes with ALUOp=010 -> ALUCtrl matches REQ-012/013; unlisted funct -> 0010.
REQ-029 mult a=0xFFFFFFFF (-1), b=0x00000002 -> done at cycle 34, hi=0xFFFFFFFF, lo=0xFFFFFFFE; multu same operands -> hi=0x00000001, lo=0xFFFFFFFE.
REQ-030 div a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu a=7, b=2 -> lo=3, hi=1.
REQ-031 div a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0; divu a=5, b=0 -> done at cycle 2, lo=0xFFFFFFFF, hi=5.
REQ-032 Start mult, re-pulse start at cycle 10 with other operands, then rst at cycle 20 -> second start ignored, busy/hi/lo=0 after rst edge, no done; next accepted op completes correctly.
